// File: rtl/alu_op_issuer.sv
// Issue stage in front of the combinational ALU: decodes the request into an ALU select, drives the ALU, and returns the captured result.
// ALU_PIPE_EN: when defined, adds a WAIT state so an ALU with a registered output can be used.
module alu_op_issuer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_opcode,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7_5,
  input  logic [DATA_W-1:0] req_rs1,
  input  logic [DATA_W-1:0] req_rs2,
  input  logic [DATA_W-1:0] req_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_taken,
  output logic              res_illegal
);

  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SUB = 4'd1;
  localparam logic [3:0] SEL_AND = 4'd2;
  localparam logic [3:0] SEL_OR  = 4'd3;
  localparam logic [3:0] SEL_XOR = 4'd4;
  localparam logic [3:0] SEL_SLT = 4'd5;
  localparam logic [3:0] SEL_BEQ = 4'd6;
  localparam logic [3:0] SEL_BNE = 4'd7;
  localparam logic [3:0] SEL_BLT = 4'd8;
  localparam logic [3:0] SEL_BGE = 4'd9;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_taken_q, res_taken_d;
  logic              res_illegal_q, res_illegal_d;

  logic       dec_illegal;
  logic       dec_use_imm;
  logic [3:0] dec_sel;
  logic       accept;
  logic       res_fire;
  logic       sel_is_branch;

  // Instruction decode: opcode/funct3/funct7[5] -> ALU select code
  always_comb begin
    dec_illegal = 1'b0;
    dec_use_imm = 1'b0;
    dec_sel     = SEL_ADD;
    case (req_opcode)
      OP_R, OP_I: begin
        dec_use_imm = (req_opcode == OP_I);
        case (req_funct3)
          3'b000:  dec_sel = (req_opcode == OP_R && req_funct7_5) ? SEL_SUB : SEL_ADD;
          3'b111:  dec_sel = SEL_AND;
          3'b110:  dec_sel = SEL_OR;
          3'b100:  dec_sel = SEL_XOR;
          3'b010:  dec_sel = SEL_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_B: begin
        case (req_funct3)
          3'b000:  dec_sel = SEL_BEQ;
          3'b001:  dec_sel = SEL_BNE;
          3'b100:  dec_sel = SEL_BLT;
          3'b101:  dec_sel = SEL_BGE;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign accept        = req_valid && req_ready;
  assign res_fire      = res_valid_q && res_ready;
  assign sel_is_branch = (alu_sel_q >= SEL_BEQ);

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= SEL_ADD;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_taken_q   <= res_taken_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = dec_illegal ? S_RESP : S_ISSUE;
      end
`ifdef ALU_PIPE_EN
      S_ISSUE:   state_d = S_WAIT;
`else
      S_ISSUE:   state_d = S_CAPTURE;
`endif
      S_WAIT:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        if (res_fire) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and response register updates
  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_taken_d   = res_taken_q;
    res_illegal_d = res_illegal_q;

    if (accept) begin
      res_illegal_d = dec_illegal;
      if (dec_illegal) begin
        // Illegal ops never touch the ALU drive registers
        res_data_d  = '0;
        res_taken_d = 1'b0;
      end else begin
        alu_a_d   = req_rs1;
        alu_b_d   = dec_use_imm ? req_imm : req_rs2;
        alu_sel_d = dec_sel;
      end
    end

    if (state_q == S_CAPTURE) begin
      if (sel_is_branch) begin
        res_data_d  = '0;
        res_taken_d = alu_zero;
      end else begin
        res_data_d  = alu_out;
        res_taken_d = 1'b0;
      end
    end

    // res_valid rises one cycle after RESP is entered and drops on handshake
    if (state_q == S_RESP) begin
      if (!res_valid_q)  res_valid_d = 1'b1;
      else if (res_fire) res_valid_d = 1'b0;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_taken   = res_taken_q;
  assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural ALU attached (registered when ALU_PIPE_EN is defined).
module tb_alu_op_issuer;

  localparam int DATA_W = 32;
`ifdef ALU_PIPE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [6:0]        req_opcode = '0;
  logic [2:0]        req_funct3 = '0;
  logic              req_funct7_5 = 1'b0;
  logic [DATA_W-1:0] req_rs1 = '0;
  logic [DATA_W-1:0] req_rs2 = '0;
  logic [DATA_W-1:0] req_imm = '0;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_data;
  logic              res_taken;
  logic              res_illegal;

  int errors = 0;
  int checks = 0;
  int lat;

  alu_op_issuer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_taken(res_taken), .res_illegal(res_illegal)
  );

  always #5 clk = ~clk;

  // Reference ALU; branch ops put junk (a+b) on data_out so the issuer must zero it
  function automatic logic [DATA_W:0] alu_f(input logic [3:0] s, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] o;
    logic z;
    o = '0;
    z = 1'b0;
    case (s)
      4'd0: o = a + b;
      4'd1: o = a - b;
      4'd2: o = a & b;
      4'd3: o = a | b;
      4'd4: o = a ^ b;
      4'd5: o = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd6: begin o = a + b; z = (a == b); end
      4'd7: begin o = a + b; z = (a != b); end
      4'd8: begin o = a + b; z = ($signed(a) < $signed(b)); end
      4'd9: begin o = a + b; z = ($signed(a) >= $signed(b)); end
      default: o = '0;
    endcase
    if (s < 4'd6) z = (o == '0);
    return {z, o};
  endfunction

`ifdef ALU_PIPE_EN
  always @(posedge clk) {alu_zero, alu_out} <= alu_f(alu_sel, alu_a, alu_b);
`else
  always_comb {alu_zero, alu_out} = alu_f(alu_sel, alu_a, alu_b);
`endif

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge; returns #1 after the accepting edge
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [DATA_W-1:0] imm);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_opcode = op; req_funct3 = f3; req_funct7_5 = f75;
    req_rs1 = a; req_rs2 = b; req_imm = imm;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("res_valid_after_hs", res_valid, 0);
    chk("req_ready_after_hs", req_ready, 1);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_taken", res_taken, 0);
    chk("rst_res_illegal", res_illegal, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    // R ADD 5+7
    send(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd100);
    chk("add_sel", alu_sel, 0);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    chk("add_ready_busy", req_ready, 0);
    wait_resp(lat);
    chk("add_latency", lat, LAT);
    chk("add_data", res_data, 12);
    chk("add_taken", res_taken, 0);
    chk("add_illegal", res_illegal, 0);
    handshake();

    // R SUB 3-5
    send(7'b0110011, 3'b000, 1'b1, 32'd3, 32'd5, 32'd0);
    chk("sub_sel", alu_sel, 1);
    wait_resp(lat);
    chk("sub_latency", lat, LAT);
    chk("sub_data", res_data, 32'hFFFF_FFFE);
    handshake();

    // I ADDI with f7_5 set: still ADD, operand B from imm
    send(7'b0010011, 3'b000, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFF);
    chk("addi_sel", alu_sel, 0);
    chk("addi_b", alu_b, 32'hFFFF_FFFF);
    wait_resp(lat);
    chk("addi_latency", lat, LAT);
    chk("addi_data", res_data, 9);
    handshake();

    // BEQ equal operands
    send(7'b1100011, 3'b000, 1'b0, 32'd42, 32'd42, 32'd0);
    chk("beq_sel", alu_sel, 6);
    wait_resp(lat);
    chk("beq_latency", lat, LAT);
    chk("beq_taken", res_taken, 1);
    chk("beq_data", res_data, 0);
    handshake();

    // BLT signed: -1 < 1
    send(7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("blt_sel", alu_sel, 8);
    wait_resp(lat);
    chk("blt_taken", res_taken, 1);
    handshake();

    // BNE equal operands
    send(7'b1100011, 3'b001, 1'b0, 32'd42, 32'd42, 32'd0);
    chk("bne_sel", alu_sel, 7);
    wait_resp(lat);
    chk("bne_taken", res_taken, 0);
    chk("bne_data", res_data, 0);
    handshake();

    // Illegal opcode (load): ALU drive must not change
    send(7'b0000011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3);
    chk("ill_sel_hold", alu_sel, 7);
    chk("ill_a_hold", alu_a, 42);
    wait_resp(lat);
    chk("ill_latency", lat, 1);
    chk("ill_flag", res_illegal, 1);
    chk("ill_data", res_data, 0);
    chk("ill_taken", res_taken, 0);
    chk("ill_sel_after", alu_sel, 7);
    handshake();

    // Illegal R-type funct3
    send(7'b0110011, 3'b001, 1'b0, 32'd1, 32'd2, 32'd3);
    wait_resp(lat);
    chk("ill_f3_latency", lat, 1);
    chk("ill_f3_flag", res_illegal, 1);
    handshake();

    // Back-pressure: OR held for 5 cycles while another request waits
    send(7'b0110011, 3'b110, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'd0);
    wait_resp(lat);
    chk("or_latency", lat, LAT);
    chk("or_illegal_cleared", res_illegal, 0);
    req_opcode = 7'b0110011; req_funct3 = 3'b100; req_rs1 = 32'd77;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, 32'h0000_00FF);
      chk("stall_ready", req_ready, 0);
      chk("stall_sel", alu_sel, 3);
    end
    req_valid = 1'b0;
    handshake();

    // Reset pulse while in CAPTURE, then a normal request
    send(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0);
    repeat (LAT - 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_sel", alu_sel, 0);
    chk("mid_rst_a", alu_a, 0);
    chk("mid_rst_b", alu_b, 0);
    chk("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", req_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_dropped", res_valid, 0);
    send(7'b0110011, 3'b100, 1'b0, 32'h0000_00FF, 32'h0000_000F, 32'd0);
    chk("xor_sel", alu_sel, 4);
    wait_resp(lat);
    chk("xor_latency", lat, LAT);
    chk("xor_data", res_data, 32'h0000_00F0);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
